// File: rtl/trigger_pulse_gen.sv
// Trigger evaluator: per-bit level/edge conditions, occurrence counting, single-cycle
// trigger pulse and enforced hold-off. Define TRIGGER_REARM_EN for auto re-arm and trig_count.
module trigger_pulse_gen #(
    parameter int unsigned NR_SIGNALS = 8,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned HOLDOFF    = 8
) (
    input  logic                    clk,
    input  logic                    reset_,
    input  logic [NR_SIGNALS-1:0]   signals_in,
    input  logic [3*NR_SIGNALS-1:0] trig_cond,
    input  logic [CNT_W-1:0]        trig_target,
    input  logic                    arm,
    input  logic                    disarm,
    output logic                    trigger_pulse,
    output logic                    armed,
    output logic                    triggered,
    output logic                    holdoff_active
`ifdef TRIGGER_REARM_EN
    ,
    output logic [CNT_W-1:0]        trig_count
`endif
);

    localparam int unsigned       HOLD_W    = 8;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_HOLDOFF
    } state_t;

    typedef enum logic [2:0] {
        COND_DC   = 3'b000,
        COND_LOW  = 3'b001,
        COND_HIGH = 3'b010,
        COND_RISE = 3'b011,
        COND_FALL = 3'b100,
        COND_ANY  = 3'b101
    } cond_t;

    state_t                  state_q, state_d;
    logic [NR_SIGNALS-1:0]   signals_prev;
    logic [NR_SIGNALS-1:0]   bit_ok;
    logic                    prev_valid, prev_valid_d;
    logic [3*NR_SIGNALS-1:0] cond_q;
    logic [CNT_W-1:0]        target_q, target_eff;
    logic [CNT_W-1:0]        occ_q, occ_d, occ_inc;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic                    pulse_d;
    logic                    triggered_d;
    logic                    load_cfg;
    logic                    match;
    logic                    reach;
`ifdef TRIGGER_REARM_EN
    logic [CNT_W-1:0]        count_d;
    logic                    disarm_pend, pend_d;
`endif

    // Edge conditions need a sample taken after arming; prev_valid gates them.
    always_comb begin
        bit_ok = '1;
        for (int unsigned i = 0; i < NR_SIGNALS; i++) begin
            case (cond_q[3*i +: 3])
                COND_LOW:  bit_ok[i] = ~signals_in[i];
                COND_HIGH: bit_ok[i] =  signals_in[i];
                COND_RISE: bit_ok[i] = prev_valid & ~signals_prev[i] &  signals_in[i];
                COND_FALL: bit_ok[i] = prev_valid &  signals_prev[i] & ~signals_in[i];
                COND_ANY:  bit_ok[i] = prev_valid & (signals_prev[i] ^ signals_in[i]);
                default:   bit_ok[i] = 1'b1;
            endcase
        end
    end

    assign match      = &bit_ok;
    assign target_eff = (target_q == '0) ? CNT_W'(1) : target_q;
    assign occ_inc    = (&occ_q) ? occ_q : occ_q + CNT_W'(1);
    assign reach      = ({1'b0, occ_q} + (CNT_W+1)'(1)) >= {1'b0, target_eff};

    always_comb begin
        state_d      = state_q;
        occ_d        = occ_q;
        hold_d       = hold_q;
        pulse_d      = 1'b0;
        triggered_d  = triggered;
        load_cfg     = 1'b0;
        prev_valid_d = 1'b1;
`ifdef TRIGGER_REARM_EN
        count_d      = trig_count;
        pend_d       = disarm_pend;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (arm && !disarm) begin
                    state_d      = ST_ARMED;
                    occ_d        = '0;
                    triggered_d  = 1'b0;
                    load_cfg     = 1'b1;
                    prev_valid_d = 1'b0;
`ifdef TRIGGER_REARM_EN
                    count_d      = '0;
                    pend_d       = 1'b0;
`endif
                end
            end
            ST_ARMED: begin
                if (disarm) begin
                    state_d = ST_IDLE;
                    occ_d   = '0;
                end else if (arm) begin
                    occ_d        = '0;
                    triggered_d  = 1'b0;
                    load_cfg     = 1'b1;
                    prev_valid_d = 1'b0;
`ifdef TRIGGER_REARM_EN
                    count_d      = '0;
                    pend_d       = 1'b0;
`endif
                end else if (match) begin
                    occ_d = occ_inc;
                    if (reach) begin
                        pulse_d     = 1'b1;
                        state_d     = ST_HOLDOFF;
                        hold_d      = HOLD_LOAD;
                        triggered_d = 1'b1;
`ifdef TRIGGER_REARM_EN
                        count_d     = (&trig_count) ? trig_count : trig_count + CNT_W'(1);
`endif
                    end
                end
            end
            ST_HOLDOFF: begin
`ifdef TRIGGER_REARM_EN
                if (disarm) pend_d = 1'b1;
`endif
                if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else begin
`ifdef TRIGGER_REARM_EN
                    // A disarm seen at any point of the hold-off, including now, stops re-arming.
                    if (disarm_pend || disarm) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d      = ST_ARMED;
                        prev_valid_d = 1'b0;
                    end
                    occ_d  = '0;
                    pend_d = 1'b0;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q       <= ST_IDLE;
            signals_prev  <= '0;
            prev_valid    <= 1'b0;
            cond_q        <= '0;
            target_q      <= '0;
            occ_q         <= '0;
            hold_q        <= '0;
            trigger_pulse <= 1'b0;
            triggered     <= 1'b0;
`ifdef TRIGGER_REARM_EN
            trig_count    <= '0;
            disarm_pend   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            signals_prev  <= signals_in;
            prev_valid    <= prev_valid_d;
            occ_q         <= occ_d;
            hold_q        <= hold_d;
            trigger_pulse <= pulse_d;
            triggered     <= triggered_d;
`ifdef TRIGGER_REARM_EN
            trig_count    <= count_d;
            disarm_pend   <= pend_d;
`endif
            if (load_cfg) begin
                cond_q   <= trig_cond;
                target_q <= trig_target;
            end
        end
    end

    // The pulse cycle already sits in HOLDOFF but is not counted as hold-off time.
    assign armed          = (state_q == ST_ARMED);
    assign holdoff_active = (state_q == ST_HOLDOFF) && !trigger_pulse;

endmodule

// File: tb/tb_trigger_pulse_gen.sv
// Scoreboard bench for trigger_pulse_gen against a cycle-indexed behavioural model.
// Follows TRIGGER_REARM_EN when the macro is defined.
module tb_trigger_pulse_gen;

    localparam int unsigned NS   = 8;
    localparam int unsigned CW   = 16;
    localparam int          HOLD = 8;
    localparam int          CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            reset_;
    logic [NS-1:0]   signals_in;
    logic [3*NS-1:0] trig_cond;
    logic [CW-1:0]   trig_target;
    logic            arm, disarm;
    logic            trigger_pulse, armed, triggered, holdoff_active;
`ifdef TRIGGER_REARM_EN
    logic [CW-1:0]   trig_count;
`endif

    always #5 clk = ~clk;

    trigger_pulse_gen #(
        .NR_SIGNALS(NS),
        .CNT_W     (CW),
        .HOLDOFF   (HOLD)
    ) dut (
        .clk           (clk),
        .reset_        (reset_),
        .signals_in    (signals_in),
        .trig_cond     (trig_cond),
        .trig_target   (trig_target),
        .arm           (arm),
        .disarm        (disarm),
        .trigger_pulse (trigger_pulse),
        .armed         (armed),
        .triggered     (triggered),
        .holdoff_active(holdoff_active)
`ifdef TRIGGER_REARM_EN
        ,
        .trig_count    (trig_count)
`endif
    );

    typedef struct {
        logic          pulse;
        logic          armed;
        logic          trig;
        logic          hold;
        logic [CW-1:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   pulse_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    logic [3*NS-1:0] cond_v;
    logic [CW-1:0]   tgt_v;
    logic [NS-1:0]   s_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, expv);
        end
    endtask

    // Behavioural model: everything is expressed in terms of clock-edge indices.
    bit              m_armed, m_trig, m_pend;
    int              m_hits, m_target, m_count;
    int              m_valid_from, m_pulse_edge;
    logic [NS-1:0]   m_prev;
    logic [3*NS-1:0] m_cond;

    task automatic model_reset();
        m_armed = 0; m_trig = 0; m_pend = 0;
        m_hits = 0; m_target = 1; m_count = 0;
        m_valid_from = 0; m_pulse_edge = -100000;
        m_prev = '0; m_cond = '0;
    endtask

    function automatic bit model_in_hold(input int e);
        return (e > m_pulse_edge) && (e <= m_pulse_edge + HOLD + 1);
    endfunction

    function automatic bit model_match(input logic [NS-1:0] s, input int e);
        bit ok = 1'b1;
        bit edges_ok = (e >= m_valid_from);
        for (int i = 0; i < int'(NS); i++) begin
            int c = int'(m_cond[3*i +: 3]);
            case (c)
                1: ok = ok && !s[i];
                2: ok = ok && s[i];
                3: ok = ok && edges_ok && !m_prev[i] && s[i];
                4: ok = ok && edges_ok && m_prev[i] && !s[i];
                5: ok = ok && edges_ok && (m_prev[i] != s[i]);
                default: ;
            endcase
        end
        return ok;
    endfunction

    task automatic model_step(input logic [NS-1:0] s, input bit a, input bit d,
                              input logic [3*NS-1:0] c, input logic [CW-1:0] t,
                              input int e, output exp_t x);
        bit pulse = 1'b0;
        if (model_in_hold(e)) begin
            if (d) m_pend = 1;
            if (e == m_pulse_edge + HOLD + 1) begin
`ifdef TRIGGER_REARM_EN
                if (!m_pend) begin
                    m_armed = 1; m_hits = 0; m_valid_from = e + 2;
                end
`endif
                m_pend = 0;
            end
        end else if (m_armed && d) begin
            m_armed = 0; m_hits = 0;
        end else if (a && !d) begin
            m_armed = 1; m_hits = 0; m_cond = c;
            m_target = (t == '0) ? 1 : int'(t);
            m_trig = 0; m_count = 0; m_pend = 0; m_valid_from = e + 2;
        end else if (m_armed && model_match(s, e)) begin
            if (m_hits < CMAX) m_hits++;
            if (m_hits >= m_target) begin
                pulse = 1; m_pulse_edge = e; m_armed = 0; m_trig = 1;
                if (m_count < CMAX) m_count++;
            end
        end
        m_prev  = s;
        x.pulse = pulse;
        x.armed = m_armed;
        x.trig  = m_trig;
        x.hold  = (e > m_pulse_edge) && (e <= m_pulse_edge + HOLD);
        x.count = CW'(m_count);
    endtask

    // Monitor: pops one expectation per clock and matches pulse events by cycle.
    exp_t mon_x;
    int   mon_pc;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_x = exp_q.pop_front();
            chk("trigger_pulse", 32'(trigger_pulse), 32'(mon_x.pulse));
            chk("armed", 32'(armed), 32'(mon_x.armed));
            chk("triggered", 32'(triggered), 32'(mon_x.trig));
            chk("holdoff_active", 32'(holdoff_active), 32'(mon_x.hold));
`ifdef TRIGGER_REARM_EN
            chk("trig_count", 32'(trig_count), 32'(mon_x.count));
`endif
        end
        if (trigger_pulse === 1'b1) begin
            chk("pulse_event_pending", 32'(pulse_q.size() > 0), 32'd1);
            if (pulse_q.size() > 0) begin
                mon_pc = pulse_q.pop_front();
                chk("pulse_event_cycle", 32'(cyc), 32'(mon_pc));
            end
        end
    end

    task automatic step(input logic [NS-1:0] s, input logic a, input logic d);
        exp_t x;
        signals_in  = s;
        arm         = a;
        disarm      = d;
        trig_cond   = cond_v;
        trig_target = tgt_v;
        model_step(s, a, d, cond_v, tgt_v, cyc + 1, x);
        @(posedge clk);
        cyc++;
        exp_q.push_back(x);
        if (x.pulse) pulse_q.push_back(cyc);
        @(negedge clk);
    endtask

    task automatic reset_cycles(input int n);
        exp_t z;
        z = '{pulse: 1'b0, armed: 1'b0, trig: 1'b0, hold: 1'b0, count: '0};
        repeat (n) begin
            @(posedge clk);
            cyc++;
            exp_q.push_back(z);
            @(negedge clk);
        end
    endtask

    task automatic async_reset();
        #2 reset_ = 1'b0;
        #1;
        chk("rst_trigger_pulse", 32'(trigger_pulse), 32'd0);
        chk("rst_armed", 32'(armed), 32'd0);
        chk("rst_triggered", 32'(triggered), 32'd0);
        chk("rst_holdoff_active", 32'(holdoff_active), 32'd0);
`ifdef TRIGGER_REARM_EN
        chk("rst_trig_count", 32'(trig_count), 32'd0);
`endif
        model_reset();
        reset_cycles(2);
        reset_ = 1'b1;
    endtask

    task automatic settle();
        repeat (HOLD + 3) step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0);
    endtask

    function automatic logic [3*NS-1:0] rand_cond();
        logic [3*NS-1:0] c = '0;
        for (int i = 0; i < int'(NS); i++)
            if ($urandom_range(0, 9) < 3) c[3*i +: 3] = 3'($urandom_range(1, 7));
        return c;
    endfunction

    initial begin
        reset_ = 1'b1; signals_in = '0; arm = 1'b0; disarm = 1'b0;
        trig_cond = '0; trig_target = '0;
        cond_v = '0; tgt_v = CW'(1); s_v = '0;
        model_reset();
        #1 reset_ = 1'b0;
        @(negedge clk);
        reset_cycles(3);
        reset_ = 1'b1;
        repeat (3) step('0, 1'b0, 1'b0);

        // Level trigger: bit0 high, target 1, match ten cycles after arm.
        cond_v = 24'h000002; tgt_v = CW'(1);
        step('0, 1'b1, 1'b0);
        repeat (9) step('0, 1'b0, 1'b0);
        step(8'h01, 1'b0, 1'b0);
        repeat (12) step('0, 1'b0, 1'b0);
        settle();

        // Occurrence count: third rising edge on bit3.
        cond_v = 24'h000600; tgt_v = CW'(3);
        step('0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        repeat (3) begin
            step(8'h08, 1'b0, 1'b0);
            step('0, 1'b0, 1'b0);
        end
        settle();

        // Edges at or right after arm never count.
        cond_v = 24'h000003; tgt_v = CW'(1);
        step('0, 1'b0, 1'b0);
        step(8'h01, 1'b1, 1'b0);
        step(8'h01, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        step(8'h01, 1'b0, 1'b0);
        settle();
        step('0, 1'b1, 1'b0);
        step(8'h01, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        step(8'h01, 1'b0, 1'b0);
        settle();

        // Disarm races.
        cond_v = 24'h000002; tgt_v = CW'(1);
        step('0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        step(8'h01, 1'b0, 1'b1);
        step('0, 1'b1, 1'b1);
        step(8'h01, 1'b0, 1'b0);
        settle();

        // All don't care: hold-off spacing, arm during hold-off dropped.
        cond_v = '0; tgt_v = CW'(1);
        step('0, 1'b1, 1'b0);
        for (int k = 0; k < 35; k++)
            step(NS'($urandom), model_in_hold(cyc + 1) && (k % 4 == 1), 1'b0);
        settle();

        // Async reset on the pulse cycle, then mid hold-off.
        cond_v = '0; tgt_v = CW'(1);
        step('0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        async_reset();
        repeat (4) step('0, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0);
        repeat (4) step('0, 1'b0, 1'b0);
        async_reset();
        repeat (12) step(NS'($urandom), 1'b0, 1'b0);

        // Randomised traffic; config inputs change every cycle but only latch on arm.
        for (int k = 0; k < 2500; k++) begin
            int   b;
            logic a, d;
            if ($urandom_range(0, 2) == 0) begin
                b = $urandom_range(0, NS - 1);
                s_v[b] = ~s_v[b];
            end
            cond_v = rand_cond();
            tgt_v  = CW'($urandom_range(0, 4));
            a = ($urandom_range(0, 19) == 0);
            d = ($urandom_range(0, 39) == 0);
            step(s_v, a, d);
        end

        #1;
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("pulse_queue_drained", 32'(pulse_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
